// File: rtl/mem_ctrl8x8.sv
// Request/response sequencer for the memory8x8 array: setup, strobe and hold phases per access.
// Define MEM_CTRL_INIT_EN to compile in the power-up fill of INIT_VALUE into all eight words.
module mem_ctrl8x8 #(
  parameter int         STROBE_CYCLES = 1,
  parameter logic [7:0] INIT_VALUE    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [2:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       init_done,
  output logic [2:0] mem_address,
  output logic [7:0] mem_data_in,
  output logic       mem_select,
  output logic       mem_rw,
  input  logic [7:0] mem_data_out
);

`ifdef MEM_CTRL_INIT_EN
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, INIT_SETUP, INIT_STROBE, INIT_HOLD
  } state_e;
  localparam state_e RESET_STATE = INIT_SETUP;
  logic init_done_q;
`else
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  localparam state_e RESET_STATE = IDLE;
  wire unused_init_value = ^INIT_VALUE;
`endif

  localparam logic [1:0] LAST_STROBE = 2'(STROBE_CYCLES - 1);

  state_e     state_q;
  logic [1:0] cnt_q;
  logic [2:0] addr_q;
  logic [7:0] wdata_q;
  logic       rw_q;
  logic       select_q;
  logic       rsp_valid_q;
  logic [7:0] rdata_q;
  logic       accept;

`ifdef MEM_CTRL_INIT_EN
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  assign req_ready   = (state_q == IDLE) && init_done;
  assign accept      = req_valid && req_ready;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rdata_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_select  = select_q;
  assign mem_rw      = rw_q;

  // Address, rw and data only move on edges where select is low on both sides.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= 2'd0;
      addr_q      <= 3'd0;
      wdata_q     <= 8'd0;
      rw_q        <= 1'b1;
      select_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'd0;
`ifdef MEM_CTRL_INIT_EN
      init_done_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            rw_q    <= req_rw;
            wdata_q <= req_wdata;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          select_q <= 1'b1;
          cnt_q    <= 2'd0;
          state_q  <= STROBE;
        end
        STROBE: begin
          if (cnt_q == LAST_STROBE) begin
            select_q <= 1'b0;
            if (rw_q) begin
              rdata_q     <= mem_data_out;
              rsp_valid_q <= 1'b1;
            end
            state_q <= HOLD;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        HOLD: begin
          rw_q    <= 1'b1;
          state_q <= IDLE;
        end
`ifdef MEM_CTRL_INIT_EN
        // The first INIT_SETUP cycle stands in for the IDLE/accept cycle of a normal write.
        INIT_SETUP: begin
          if (cnt_q == 2'd0) begin
            wdata_q <= INIT_VALUE;
            rw_q    <= 1'b0;
            cnt_q   <= 2'd1;
          end else begin
            select_q <= 1'b1;
            cnt_q    <= 2'd0;
            state_q  <= INIT_STROBE;
          end
        end
        INIT_STROBE: begin
          if (cnt_q == LAST_STROBE) begin
            select_q <= 1'b0;
            state_q  <= INIT_HOLD;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        INIT_HOLD: begin
          if (addr_q == 3'd7) begin
            init_done_q <= 1'b1;
            rw_q        <= 1'b1;
            state_q     <= IDLE;
          end else begin
            addr_q  <= addr_q + 3'd1;
            cnt_q   <= 2'd0;
            state_q <= INIT_SETUP;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl8x8.sv
// Directed bench for mem_ctrl8x8: one instance with STROBE_CYCLES=1, one with 3, behavioural memories.
// Covers the MEM_CTRL_INIT_EN fill when that macro is defined for the build.
module tb_mem_ctrl8x8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid1, req_valid3;
  logic       req_rw;
  logic [2:0] req_addr;
  logic [7:0] req_wdata;

  logic       req_ready1, rsp_valid1, init_done1, mem_select1, mem_rw1;
  logic [7:0] rsp_rdata1, mem_data_in1, mem_data_out1;
  logic [2:0] mem_address1;
  logic       req_ready3, rsp_valid3, init_done3, mem_select3, mem_rw3;
  logic [7:0] rsp_rdata3, mem_data_in3, mem_data_out3;
  logic [2:0] mem_address3;

  int checks = 0;
  int failures = 0;

  mem_ctrl8x8 #(.STROBE_CYCLES(1), .INIT_VALUE(8'h3C)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .init_done(init_done1),
    .mem_address(mem_address1), .mem_data_in(mem_data_in1), .mem_select(mem_select1),
    .mem_rw(mem_rw1), .mem_data_out(mem_data_out1)
  );

  mem_ctrl8x8 #(.STROBE_CYCLES(3), .INIT_VALUE(8'h3C)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .init_done(init_done3),
    .mem_address(mem_address3), .mem_data_in(mem_data_in3), .mem_select(mem_select3),
    .mem_rw(mem_rw3), .mem_data_out(mem_data_out3)
  );

  // Behavioural stand-ins for memory8x8: write while selected with rw=0, read combinationally.
  logic [7:0] mem1 [8];
  logic [7:0] mem3 [8];
  initial begin
    for (int i = 0; i < 8; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
  end
  always @(posedge clk) if (mem_select1 && !mem_rw1) mem1[mem_address1] <= mem_data_in1;
  always @(posedge clk) if (mem_select3 && !mem_rw3) mem3[mem_address3] <= mem_data_in3;
  assign mem_data_out1 = mem1[mem_address1];
  assign mem_data_out3 = mem3[mem_address3];

  // Protocol monitor state, index 0 = dut1, 1 = dut3.
  logic        prevValid [2];
  logic        prevSel   [2];
  logic [11:0] prevBus   [2];
  int          runLen    [2];

  task automatic monitor(input int i, input logic sel, input logic rw, input logic [2:0] addr,
                         input logic [7:0] data, input logic rv, input logic rdy, input int expLen);
    if (!rst_n) begin
      prevValid[i] = 1'b0;
      prevSel[i]   = 1'b0;
      runLen[i]    = 0;
    end else begin
      checks++;
      if (rv && rdy) begin
        failures++;
        $display("[TB] FAIL rsp_ready_overlap dut%0d: rsp_valid=%b req_ready=%b, required not both 1", i, rv, rdy);
      end
      if (prevValid[i] && (prevSel[i] || sel)) begin
        checks++;
        if ({addr, rw, data} !== prevBus[i]) begin
          failures++;
          $display("[TB] FAIL bus_stable dut%0d: got %h, required %h", i, {addr, rw, data}, prevBus[i]);
        end
      end
      if (sel) runLen[i]++;
      else if (runLen[i] != 0) begin
        checks++;
        if (runLen[i] != expLen) begin
          failures++;
          $display("[TB] FAIL select_width dut%0d: got %0d cycles, required %0d", i, runLen[i], expLen);
        end
        runLen[i] = 0;
      end
      prevSel[i]   = sel;
      prevBus[i]   = {addr, rw, data};
      prevValid[i] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    monitor(0, mem_select1, mem_rw1, mem_address1, mem_data_in1, rsp_valid1, req_ready1, 1);
    monitor(1, mem_select3, mem_rw3, mem_address3, mem_data_in3, rsp_valid3, req_ready3, 3);
  end

  // Called at posedge+2; returns at accept edge+2 with req_valid dropped.
  task automatic issue(input int which, input logic rw, input logic [2:0] a, input logic [7:0] d,
                       output int waited);
    req_rw = rw;
    req_addr = a;
    req_wdata = d;
    if (which == 1) req_valid1 = 1'b1;
    else req_valid3 = 1'b1;
    waited = 0;
    while (((which == 1) ? !req_ready1 : !req_ready3) && waited < 100) begin
      @(posedge clk); #2;
      waited++;
    end
    if (waited >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL issue_timeout dut%0d: req_ready stayed 0 for %0d cycles, required 1", which, waited);
    end
    @(posedge clk); #2;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
  endtask

  task automatic waitRsp(input int which, output int lat, output logic [7:0] data);
    logic rv;
    lat = 0;
    rv = 1'b0;
    while (!rv && lat < 20) begin
      @(negedge clk);
      lat++;
      rv = (which == 1) ? rsp_valid1 : rsp_valid3;
    end
    data = (which == 1) ? rsp_rdata1 : rsp_rdata3;
    @(posedge clk); #2;
  endtask

  task automatic waitInit(output int n1, output int n3, output logic anyRsp);
    int n;
    n = 0;
    n1 = -1;
    n3 = -1;
    anyRsp = 1'b0;
    while (!(init_done1 && init_done3) && n < 300) begin
      @(posedge clk); #1;
      n++;
      if (init_done1 && n1 < 0) n1 = n;
      if (init_done3 && n3 < 0) n3 = n;
      if (rsp_valid1 || rsp_valid3) anyRsp = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic expDone;
    int n1, n3;
    logic anyRsp;
`ifdef MEM_CTRL_INIT_EN
    expDone = 1'b0;
`else
    expDone = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_select1, mem_rw1, mem_address1, mem_data_in1} !== {1'b0, 1'b1, 3'd0, 8'd0}) begin
      failures++;
      $display("[TB] FAIL reset_mem_bus: got %h, required %h", {mem_select1, mem_rw1, mem_address1, mem_data_in1}, {1'b0, 1'b1, 3'd0, 8'd0});
    end
    checks++;
    if ({rsp_valid1, rsp_rdata1} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_rsp: got %h, required 000", {rsp_valid1, rsp_rdata1});
    end
    checks++;
    if ({init_done1, req_ready1, init_done3, req_ready3} !== {4{expDone}}) begin
      failures++;
      $display("[TB] FAIL reset_ready_done: got %b, required %b", {init_done1, req_ready1, init_done3, req_ready3}, {4{expDone}});
    end
    @(posedge clk); #2;
    waitInit(n1, n3, anyRsp);
    checks++;
    if (!(init_done1 && init_done3)) begin
      failures++;
      $display("[TB] FAIL reset_init_done: got %b%b, required 11", init_done1, init_done3);
    end
  endtask

  task automatic test_write_read();
    int w, lat;
    logic [7:0] data;
    logic seen;
    issue(1, 1'b0, 3'd3, 8'hA5, w);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL write_no_rsp: rsp_valid seen=%b, required 0", seen);
    end
    checks++;
    if ({mem_select1, mem_rw1, mem_address1, mem_data_in1} !== {1'b0, 1'b1, 3'd3, 8'hA5}) begin
      failures++;
      $display("[TB] FAIL idle_bus_after_write: got %h, required %h", {mem_select1, mem_rw1, mem_address1, mem_data_in1}, {1'b0, 1'b1, 3'd3, 8'hA5});
    end
    @(posedge clk); #2;
    issue(1, 1'b1, 3'd3, 8'h00, w);
    checks++;
    if (w !== 0) begin
      failures++;
      $display("[TB] FAIL read_ready_idle: waited %0d, required 0", w);
    end
    waitRsp(1, lat, data);
    checks++;
    if (lat !== 3 || data !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL read_a5: latency %0d data %h, required 3 and a5", lat, data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid1 !== 1'b0 || rsp_rdata1 !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL rsp_pulse_hold: rsp_valid=%b rdata=%h, required 0 and a5", rsp_valid1, rsp_rdata1);
    end
    @(posedge clk); #2;
  endtask

  task automatic test_back_to_back();
    int w, lat;
    logic [7:0] data;
    for (int k = 0; k < 8; k++) begin
      issue(1, 1'b0, 3'(k), 8'h10 + 8'(k), w);
      if (k > 0) begin
        checks++;
        if (w !== 3) begin
          failures++;
          $display("[TB] FAIL write_period k=%0d: waited %0d cycles, required 3", k, w);
        end
      end
    end
    for (int k = 7; k >= 0; k--) begin
      issue(1, 1'b1, 3'(k), 8'h00, w);
      waitRsp(1, lat, data);
      checks++;
      if (lat !== 3 || data !== 8'h10 + 8'(k)) begin
        failures++;
        $display("[TB] FAIL readback k=%0d: latency %0d data %h, required 3 and %h", k, lat, data, 8'h10 + 8'(k));
      end
    end
  endtask

  task automatic test_busy_hold();
    int w, busy, lat;
    logic [7:0] data;
    issue(1, 1'b0, 3'd2, 8'h77, w);
    req_valid1 = 1'b1;
    req_rw = 1'b1;
    busy = 0;
    while (!req_ready1 && busy < 100) begin
      req_addr = 3'(7 - busy);
      @(posedge clk); #2;
      busy++;
    end
    req_addr = 3'd2;
    @(posedge clk); #2;
    req_valid1 = 1'b0;
    checks++;
    if (busy !== 3) begin
      failures++;
      $display("[TB] FAIL busy_cycles: got %0d, required 3", busy);
    end
    checks++;
    if (mem_address1 !== 3'd2 || mem_rw1 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL busy_addr_latched: addr %0d rw %b, required 2 and 1", mem_address1, mem_rw1);
    end
    waitRsp(1, lat, data);
    checks++;
    if (data !== 8'h77) begin
      failures++;
      $display("[TB] FAIL busy_read_data: got %h, required 77", data);
    end
  endtask

  task automatic test_strobe3();
    int w, lat;
    logic [7:0] data;
    issue(3, 1'b0, 3'd6, 8'h5A, w);
    issue(3, 1'b1, 3'd6, 8'h00, w);
    checks++;
    if (w !== 5) begin
      failures++;
      $display("[TB] FAIL s3_period: waited %0d cycles, required 5", w);
    end
    waitRsp(3, lat, data);
    checks++;
    if (lat !== 5 || data !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL s3_read: latency %0d data %h, required 5 and 5a", lat, data);
    end
  endtask

  task automatic test_reset_mid();
    int w, n1, n3;
    logic seen, anyRsp, expReady;
`ifdef MEM_CTRL_INIT_EN
    expReady = 1'b0;
`else
    expReady = 1'b1;
`endif
    issue(1, 1'b0, 3'd4, 8'h99, w);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_select1 !== 1'b1 || mem_rw1 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_in_strobe: select %b rw %b, required 1 and 0", mem_select1, mem_rw1);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_select1, mem_rw1, rsp_valid1, req_ready1} !== {1'b0, 1'b1, 1'b0, expReady}) begin
      failures++;
      $display("[TB] FAIL reset_mid_after: sel/rw/rsp/ready %b, required %b", {mem_select1, mem_rw1, rsp_valid1, req_ready1}, {1'b0, 1'b1, 1'b0, expReady});
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_rsp: rsp_valid seen=%b, required 0", seen);
    end
    @(posedge clk); #2;
    waitInit(n1, n3, anyRsp);
  endtask

`ifdef MEM_CTRL_INIT_EN
  task automatic test_init();
    int n1, n3, lat, w;
    logic anyRsp;
    logic [7:0] data;
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    waitInit(n1, n3, anyRsp);
    checks++;
    if (n1 !== 32 || n3 !== 48) begin
      failures++;
      $display("[TB] FAIL init_time: dut1 %0d dut3 %0d cycles, required 32 and 48", n1, n3);
    end
    checks++;
    if (anyRsp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL init_no_rsp: rsp_valid seen=%b, required 0", anyRsp);
    end
    for (int k = 0; k < 8; k++) begin
      issue(1, 1'b1, 3'(k), 8'h00, w);
      waitRsp(1, lat, data);
      checks++;
      if (data !== 8'h3C) begin
        failures++;
        $display("[TB] FAIL init_value k=%0d: got %h, required 3c", k, data);
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req_valid1 = 1'b0;
    req_valid3 = 1'b0;
    req_rw = 1'b0;
    req_addr = 3'd0;
    req_wdata = 8'd0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_busy_hold();
    test_strobe3();
    test_reset_mid();
`ifdef MEM_CTRL_INIT_EN
    test_init();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
